mac_mult_fetch: RTL and testbench
=================================

Name: mac_mult_fetch

Overview:
- Front-end stage of the matrix-multiply MAC datapath. Directly upstream of the MAC accumulate stage.
- Sequences the (i, j, k) loop over A[M x K] and B[K x N]. Issues synchronous reads to the A and B memories and multiplies the returned operands.
- Presents a registered product together with its loop indices and a valid strobe (mult_done_reg) to the accumulate stage.
- Started by a one-cycle start pulse. A synchronous stop aborts the operation.

Parameters:
- M, 4: rows of A and of C; must be >= 2.
- K, 4: columns of A / rows of B (reduction depth); must be >= 2.
- N, 4: columns of B and of C; must be >= 2.
- DATA_WIDTH_INIT_MATRIX, 32: element width of A and B (unsigned).

Ports:
- clk  in  1  sole clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begins a full multiply when idle.
- stop  in  1  synchronous abort.
- busy  out  1  high from the first issue cycle until the last product has been presented.
- re_a  out  1  read enable, A memory.
- row_addr_a  out  clog2(M)  A row address (i).
- col_addr_a  out  clog2(K)  A column address (k).
- re_b  out  1  read enable, B memory.
- row_addr_b  out  clog2(K)  B row address (k).
- col_addr_b  out  clog2(N)  B column address (j).
- data_in_a  in  DATA_WIDTH_INIT_MATRIX  A read data, valid 1 cycle after re_a.
- data_in_b  in  DATA_WIDTH_INIT_MATRIX  B read data, valid 1 cycle after re_b.
- product_reg  out  2*DATA_WIDTH_INIT_MATRIX  registered A*B.
- matrix_a_row_addr_counter_reg  out  clog2(M)  i of the product currently presented.
- matrix_a_col_addr_counter_reg  out  clog2(K)  k of the product currently presented.
- matrix_b_row_addr_counter_reg  out  clog2(K)  k of the product currently presented (always equal to the A column index).
- matrix_b_col_addr_counter_reg  out  clog2(N)  j of the product currently presented.
- mult_done_reg  out  1  product_reg and index outputs valid this cycle.

Behaviour:
- Reset (async, resetn=0): FSM = IDLE. Every output is 0: busy, re_a, re_b, all address outputs, product_reg, all counter_reg outputs, mult_done_reg. All pipeline valid bits are cleared.
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE -> ISSUE when start=1 and stop=0 are sampled at a clock edge.
  - ISSUE -> DRAIN after the issue cycle for (i=M-1, j=N-1, k=K-1).
  - DRAIN -> IDLE once both pipeline stages are empty (2 cycles).
  - Any state -> IDLE on stop=1.
- Loop order: k innermost, then j, then i. Each counter wraps to 0 and carries into the next outer counter.
  - Total issue cycles = M*N*K. There are no bubbles while in ISSUE.
- Issue cycle (stage 0):
  - re_a = re_b = 1.
  - row_addr_a = i, col_addr_a = k, row_addr_b = k, col_addr_b = j.
  - Outside ISSUE, re_a = re_b = 0 and the address outputs hold their last value.
- Stage 1 (one cycle later): data_in_a and data_in_b are valid. Indices (i, j, k) and a valid bit are carried forward in registers.
- Stage 2 (two cycles after issue):
  - product_reg <= data_in_a * data_in_b, an unsigned full-width product with no truncation.
  - The counter_reg outputs are loaded with the stage-1 indices.
  - mult_done_reg <= stage-1 valid.
- Latency: issue to mult_done_reg = exactly 2 cycles. Throughput: one product per cycle.
- Output hold: when mult_done_reg=0, product_reg and the counter_reg outputs hold their previous values.
- busy: asserted in the first ISSUE cycle. Deasserted in the cycle after the last mult_done_reg pulse.
- start while busy is ignored; the current operation is unaffected.
- stop:
  - Sampled at edge E: the FSM is in IDLE after E, and both pipeline valid bits are cleared at E.
  - mult_done_reg is therefore 0 after E, even if products were in flight. Those products are discarded.
  - re_a and re_b are 0 after E. The loop counters reset to 0.
  - start and stop sampled together: stop wins and the block stays IDLE.
- Back-to-back runs: start may be accepted in the first IDLE cycle after DRAIN. The new run restarts at (0,0,0).
- Async reset mid-operation: the block returns to the reset state immediately. No partial outputs are produced.

Test Plan:
- Reset: hold resetn=0 with start=1 -> all outputs 0, busy=0, no re_a pulses.
- Full run, defaults: A[i][k]=i+k+1, B[k][j]=k+j+1, pulse start. Required response:
  - re_a high for 64 consecutive cycles.
  - mult_done_reg high for 64 consecutive cycles, starting 2 cycles after the first re_a.
  - First product = 1 (indices 0,0,0). Product at (i=1, j=2, k=3) = 5*6 = 30.
  - Last product = 7*7 = 49 (indices 3,3,3).
  - busy high for 66 cycles.
- Width boundary: A = B = 0xFFFFFFFF everywhere -> product_reg = 0xFFFFFFFE00000001 on every valid cycle.
- Abort: stop=1 on the 10th issue cycle -> mult_done_reg=0 and busy=0 from the next cycle. No further re_a pulses. A following start produces a first product with indices (0,0,0).
- Start while busy: second start pulse at issue cycle 5 -> exactly 64 products total, index sequence unbroken.
- start and stop in the same cycle from IDLE -> no re_a, busy stays 0. Async reset mid-run (cycle 20) -> all outputs 0 immediately.

Source files
------------

// File: rtl/mac_mult_fetch.sv
// Front end of the matrix-multiply MAC: walks the (i, j, k) loop, reads A and B,
// and hands a registered product plus its indices to the accumulate stage.
module mac_mult_fetch #(
    parameter int M                      = 4,
    parameter int K                      = 4,
    parameter int N                      = 4,
    parameter int DATA_WIDTH_INIT_MATRIX = 32
) (
    input  logic                                  clk,
    input  logic                                  resetn,
    input  logic                                  start,
    input  logic                                  stop,
    output logic                                  busy,
    output logic                                  re_a,
    output logic [$clog2(M)-1:0]                  row_addr_a,
    output logic [$clog2(K)-1:0]                  col_addr_a,
    output logic                                  re_b,
    output logic [$clog2(K)-1:0]                  row_addr_b,
    output logic [$clog2(N)-1:0]                  col_addr_b,
    input  logic [DATA_WIDTH_INIT_MATRIX-1:0]     data_in_a,
    input  logic [DATA_WIDTH_INIT_MATRIX-1:0]     data_in_b,
    output logic [2*DATA_WIDTH_INIT_MATRIX-1:0]   product_reg,
    output logic [$clog2(M)-1:0]                  matrix_a_row_addr_counter_reg,
    output logic [$clog2(K)-1:0]                  matrix_a_col_addr_counter_reg,
    output logic [$clog2(K)-1:0]                  matrix_b_row_addr_counter_reg,
    output logic [$clog2(N)-1:0]                  matrix_b_col_addr_counter_reg,
    output logic                                  mult_done_reg
);

    localparam int MW     = $clog2(M);
    localparam int KW     = $clog2(K);
    localparam int NW     = $clog2(N);
    localparam int PW     = 2 * DATA_WIDTH_INIT_MATRIX;
    localparam int STAGES = 2;

    localparam logic [MW-1:0] I_LAST = MW'(M - 1);
    localparam logic [NW-1:0] J_LAST = NW'(N - 1);
    localparam logic [KW-1:0] K_LAST = KW'(K - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    typedef struct packed {
        logic [MW-1:0] i;
        logic [NW-1:0] j;
        logic [KW-1:0] k;
    } idx_t;

    state_t            state, state_nxt;
    idx_t              cnt, cnt_nxt;
    idx_t              addr_hold, addr_src;
    idx_t              s1_idx, out_idx;
    logic [STAGES:1]   vld_pipe;
    logic              issue, last_issue;

    assign issue      = (state == ISSUE);
    assign last_issue = issue && (cnt.i == I_LAST) && (cnt.j == J_LAST) && (cnt.k == K_LAST);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)        state_nxt = ISSUE;
            ISSUE:   if (last_issue)   state_nxt = DRAIN;
            DRAIN:   if (!vld_pipe[1]) state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
        if (stop) state_nxt = IDLE;
    end

    // ---------------------------------------------------- loop counters
    // k innermost, then j, then i; the final issue wraps everything to 0,
    // so a following run always starts from (0,0,0).
    always_comb begin
        cnt_nxt = cnt;
        if (stop || !issue) begin
            cnt_nxt = '0;
        end else if (cnt.k != K_LAST) begin
            cnt_nxt.k = cnt.k + KW'(1);
        end else begin
            cnt_nxt.k = '0;
            if (cnt.j != J_LAST) begin
                cnt_nxt.j = cnt.j + NW'(1);
            end else begin
                cnt_nxt.j = '0;
                cnt_nxt.i = (cnt.i == I_LAST) ? '0 : cnt.i + MW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt       <= '0;
            addr_hold <= '0;
        end else begin
            cnt <= cnt_nxt;
            if (issue) addr_hold <= cnt;
        end
    end

    // Addresses follow the live counters while issuing, and freeze on the
    // last issued address otherwise (the counters themselves wrap to 0).
    assign addr_src   = issue ? cnt : addr_hold;
    assign re_a       = issue;
    assign re_b       = issue;
    assign row_addr_a = addr_src.i;
    assign col_addr_a = addr_src.k;
    assign row_addr_b = addr_src.k;
    assign col_addr_b = addr_src.j;
    assign busy       = (state != IDLE);

    // ------------------------------------------------------- pipeline
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_pipe <= '0;
            s1_idx   <= '0;
        end else begin
            vld_pipe[1] <= issue && !stop;
            vld_pipe[2] <= vld_pipe[1] && !stop;
            if (issue) s1_idx <= cnt;
        end
    end

    // Stage 2: operands arrived this cycle; an abort discards them.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            product_reg <= '0;
            out_idx     <= '0;
        end else if (vld_pipe[1] && !stop) begin
            product_reg <= PW'(data_in_a) * PW'(data_in_b);
            out_idx     <= s1_idx;
        end
    end

    assign mult_done_reg                 = vld_pipe[2];
    assign matrix_a_row_addr_counter_reg = out_idx.i;
    assign matrix_a_col_addr_counter_reg = out_idx.k;
    assign matrix_b_row_addr_counter_reg = out_idx.k;
    assign matrix_b_col_addr_counter_reg = out_idx.j;

endmodule

// File: tb/tb_mac_mult_fetch.sv
// Scoreboard bench for mac_mult_fetch: expected products are queued at start,
// a negedge monitor pops and compares every presented product.
module tb_mac_mult_fetch;

    logic        clk = 1'b0;
    logic        resetn, start, stop;
    logic        busy, re_a, re_b, mult_done_reg;
    logic [1:0]  row_addr_a, col_addr_a, row_addr_b, col_addr_b;
    logic [1:0]  a_row_cnt, a_col_cnt, b_row_cnt, b_col_cnt;
    logic [31:0] data_in_a = '0, data_in_b = '0;
    logic [63:0] product_reg;

    mac_mult_fetch dut (
        .clk(clk), .resetn(resetn), .start(start), .stop(stop), .busy(busy),
        .re_a(re_a), .row_addr_a(row_addr_a), .col_addr_a(col_addr_a),
        .re_b(re_b), .row_addr_b(row_addr_b), .col_addr_b(col_addr_b),
        .data_in_a(data_in_a), .data_in_b(data_in_b), .product_reg(product_reg),
        .matrix_a_row_addr_counter_reg(a_row_cnt),
        .matrix_a_col_addr_counter_reg(a_col_cnt),
        .matrix_b_row_addr_counter_reg(b_row_cnt),
        .matrix_b_col_addr_counter_reg(b_col_cnt),
        .mult_done_reg(mult_done_reg)
    );

    always #5 clk = ~clk;

    // synchronous-read memories
    logic [31:0] mem_a [4][4];
    logic [31:0] mem_b [4][4];
    always @(posedge clk) begin
        if (re_a) data_in_a <= mem_a[row_addr_a][col_addr_a];
        if (re_b) data_in_b <= mem_b[row_addr_b][col_addr_b];
    end

    typedef struct {
        logic [63:0] p;
        logic [1:0]  i, j, k;
    } exp_t;
    exp_t exp_q[$];

    int total = 0, bad = 0, n_pop = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic logic [127:0] allouts();
        return {44'd0, busy, re_a, re_b, row_addr_a, col_addr_a, row_addr_b, col_addr_b,
                product_reg, a_row_cnt, a_col_cnt, b_row_cnt, b_col_cnt, mult_done_reg};
    endfunction

    function automatic logic [127:0] word(input logic [63:0] p, input logic [1:0] i,
                                          input logic [1:0] ka, input logic [1:0] kb,
                                          input logic [1:0] j);
        return {56'd0, p, i, ka, kb, j};
    endfunction

    // monitor
    always @(negedge clk) begin
        if (resetn && mult_done_reg) begin
            n_pop++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got product %0h idx %0d,%0d,%0d with nothing expected",
                         product_reg, a_row_cnt, b_col_cnt, a_col_cnt);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_product_idx",
                    word(product_reg, a_row_cnt, a_col_cnt, b_row_cnt, b_col_cnt),
                    word(e.p, e.i, e.k, e.k, e.j));
            end
        end
    end

    task automatic set_mem(input bit ones);
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                mem_a[i][k] = ones ? 32'hFFFF_FFFF : 32'(i + k + 1);
                mem_b[i][k] = ones ? 32'hFFFF_FFFF : 32'(i + k + 1);
            end
    endtask

    task automatic push_run(input bit ones);
        exp_t e;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                for (int k = 0; k < 4; k++) begin
                    e.p = ones ? 64'hFFFF_FFFE_0000_0001 : 64'((i + k + 1) * (k + j + 1));
                    e.i = 2'(i); e.j = 2'(j); e.k = 2'(k);
                    exp_q.push_back(e);
                end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    int          n_re, n_done, n_busy, first_re, first_done, re_rises, done_rises;
    logic [127:0] first_word, last_word;
    logic [63:0] prod123;

    task automatic observe(input int cycles);
        logic prev_re, prev_done;
        n_re = 0; n_done = 0; n_busy = 0; first_re = -1; first_done = -1;
        re_rises = 0; done_rises = 0; prev_re = 0; prev_done = 0;
        first_word = '0; last_word = '0; prod123 = '0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (re_a) begin
                n_re++;
                if (first_re < 0) first_re = c;
                if (!prev_re) re_rises++;
            end
            if (busy) n_busy++;
            if (mult_done_reg) begin
                n_done++;
                if (!prev_done) done_rises++;
                last_word = word(product_reg, a_row_cnt, a_col_cnt, b_row_cnt, b_col_cnt);
                if (first_done < 0) begin
                    first_done = c;
                    first_word = last_word;
                end
                if (a_row_cnt == 2'd1 && b_col_cnt == 2'd2 && a_col_cnt == 2'd3) prod123 = product_reg;
            end
            prev_re   = re_a;
            prev_done = mult_done_reg;
        end
    endtask

    initial begin
        int p0;
        bit re_seen;
        resetn = 1'b0; start = 1'b1; stop = 1'b0;
        set_mem(0);

        // reset held with start asserted
        re_seen = 0;
        repeat (3) begin
            @(negedge clk);
            chk("reset_outputs", allouts(), 128'd0);
            re_seen |= re_a;
        end
        chk("reset_no_re_a", 128'(re_seen), 128'd0);
        tick();
        start = 1'b0;
        resetn = 1'b1;
        tick();

        // full run with default pattern
        push_run(0);
        pulse_start();
        observe(80);
        chk("run_re_count", 128'(n_re), 128'd64);
        chk("run_re_contiguous", 128'(re_rises), 128'd1);
        chk("run_first_re", 128'(first_re), 128'd0);
        chk("run_done_count", 128'(n_done), 128'd64);
        chk("run_done_contiguous", 128'(done_rises), 128'd1);
        chk("run_latency", 128'(first_done), 128'd2);
        chk("run_busy_cycles", 128'(n_busy), 128'd66);
        chk("run_first_product", first_word, word(64'd1, 2'd0, 2'd0, 2'd0, 2'd0));
        chk("run_product_1_2_3", 128'(prod123), 128'd30);
        chk("run_last_product", last_word, word(64'd49, 2'd3, 2'd3, 2'd3, 2'd3));
        chk("run_addr_hold", 128'({row_addr_a, col_addr_a, row_addr_b, col_addr_b}), 128'hFF);
        chk("run_sb_drained", 128'(exp_q.size()), 128'd0);

        // width boundary
        set_mem(1);
        push_run(1);
        pulse_start();
        observe(80);
        chk("ones_done_count", 128'(n_done), 128'd64);
        chk("ones_sb_drained", 128'(exp_q.size()), 128'd0);

        // abort on the 10th issue cycle
        set_mem(0);
        push_run(0);
        p0 = n_pop;
        pulse_start();
        repeat (9) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        @(negedge clk);
        chk("abort_done_low", 128'(mult_done_reg), 128'd0);
        chk("abort_busy_low", 128'(busy), 128'd0);
        observe(10);
        chk("abort_no_re", 128'(n_re), 128'd0);
        chk("abort_no_done", 128'(n_done), 128'd0);
        chk("abort_products_seen", 128'(n_pop - p0), 128'd8);
        exp_q.delete();

        // restart after abort begins at (0,0,0)
        push_run(0);
        pulse_start();
        observe(80);
        chk("restart_done_count", 128'(n_done), 128'd64);
        chk("restart_sb_drained", 128'(exp_q.size()), 128'd0);

        // start while busy is ignored
        push_run(0);
        p0 = n_pop;
        pulse_start();
        repeat (5) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        observe(80);
        chk("rebusy_products", 128'(n_pop - p0), 128'd64);
        chk("rebusy_sb_drained", 128'(exp_q.size()), 128'd0);

        // start and stop together from idle
        tick();
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        observe(5);
        chk("startstop_no_re", 128'(n_re), 128'd0);
        chk("startstop_no_busy", 128'(n_busy), 128'd0);

        // async reset mid-run
        push_run(0);
        pulse_start();
        repeat (20) @(posedge clk);
        #3 resetn = 1'b0;
        #1 chk("async_reset_outputs", allouts(), 128'd0);
        exp_q.delete();
        tick();
        resetn = 1'b1;
        observe(5);
        chk("async_reset_idle", 128'(n_re + n_busy + n_done), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
